mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  MEM-stage data-memory access unit for the pipelined ARMv8 core; sits between EX/MEM and MEM/WB.
//  Turns LDUR/STUR-family ops (B/H/W/X, signed/unsigned) into byte-lane requests on a ready-handshake
//  data-memory port, formats load data, stalls the pipeline during the access, times out on hung memory.
// PARAMETERS
//  WAIT_LIMIT  255  max cycles in REQ before abort with bus_error; 0 = never time out
// PORTS
//  clock           in   1   rising-edge clock
//  reset           in   1   synchronous, active-high
//  mem_read        in   1   load op presented by EX/MEM
//  mem_write       in   1   store op presented by EX/MEM
//  size            in   2   00=byte 01=half 10=word 11=dword
//  sign_ext        in   1   loads: 1=sign-extend, 0=zero-extend
//  address         in   64  byte address (ALU result)
//  store_data      in   64  store operand, right-justified
//  dmem_ready      in   1   memory accepted/completed current request
//  dmem_rdata      in   64  aligned 64-bit read word, valid when dmem_ready
//  dmem_req        out  1   request strobe, held until dmem_ready
//  dmem_we         out  1   1=write, 0=read
//  dmem_addr       out  64  address with [2:0] forced to 0
//  dmem_wdata      out  64  lane-shifted store data
//  dmem_be         out  8   byte enables
//  read_data_out   out  64  formatted load data to MEM/WB
//  stall           out  1   freeze PC, IF/ID, ID/EX, EX/MEM; MEM/WB inserts bubble
//  align_fault     out  1   1-cycle pulse: misaligned access, dropped
//  bus_error       out  1   1-cycle pulse: WAIT_LIMIT expired, access aborted
// BEHAVIOUR
//  - Reset: state=IDLE, all dmem_* = 0, read_data_out = 0, stall/align_fault/bus_error = 0, counter = 0.
//  - States: IDLE, REQ, DONE.
//  - op_start = (mem_read|mem_write) & aligned in IDLE; mem_read wins if both set (treated as load).
//  - aligned: size 01 addr[0]=0; 10 addr[1:0]=0; 11 addr[2:0]=0; byte always aligned.
//  - IDLE: no op -> stay, stall=0, read_data_out=0 (pure pass-through).
//    op_start -> stall=1 combinationally; register dmem_addr/we/wdata/be, dmem_req<=1; -> REQ.
//    misaligned op -> no request, stall=0, align_fault=1 this cycle only (comb.), stay IDLE.
//  - REQ: dmem_* held stable; stall=1. dmem_ready=1 -> dmem_req<=0, latch formatted rdata
//    (loads; stores latch 0) -> DONE. Counter counts REQ cycles; when it reaches WAIT_LIMIT
//    without ready -> dmem_req<=0, bus_error pulse, -> IDLE, stall=0, no data latched.
//  - DONE: stall=0, read_data_out = latched value for this cycle only; MEM/WB captures at this edge;
//    -> IDLE. New op presented next cycle is not evaluated in DONE (one-cycle gap enforced by EX/MEM advance).
//  - Latency with zero-wait memory (ready in 1st REQ cycle): op seen cycle 0, req cycle 1, data cycle 2;
//    stall high cycles 0-1. Each extra memory wait cycle adds one stall cycle.
//  - Load formatting: lane=addr[2:0]; w = dmem_rdata >> (lane*8); truncate to size; sign_ext ? sign-extend
//    from bit 7/15/31 : zero-extend. size 11 ignores sign_ext.
//  - Store: dmem_wdata = store_data << (lane*8); dmem_be = {1,3,F,FF}[size] << lane.
//  - Inputs only sampled in IDLE; changes during REQ/DONE ignored (upstream is frozen by stall).
//  - Reset mid-REQ: dmem_req drops next edge, no completion, no bus_error.
//  - dmem_ready while not in REQ is ignored.
// TESTING
//  1 LDUR X, addr 0x1000, rdata 0x1122334455667788, ready on 1st REQ cycle -> dmem_addr 0x1000,
//    be 0x00, stall 2 cycles, read_data_out 0x1122334455667788 in DONE.
//  2 LDURSB addr 0x1003 (sign), rdata 0x0000_0000_8000_0000 -> lane 3 byte 0x80 ->
//    read_data_out 0xFFFF_FFFF_FFFF_FF80; same with sign_ext=0 -> 0x80.
//  3 STURH addr 0x2006, store_data 0xABCD -> dmem_we=1, addr 0x2000, be 0xC0,
//    wdata 0xABCD_0000_0000_0000; ready after 3 wait cycles -> stall 5 cycles total.
//  4 LDUR W addr 0x3002 -> align_fault 1 cycle, dmem_req never asserted, stall 0.
//  5 WAIT_LIMIT=4, ready held 0 -> bus_error pulse after 4 REQ cycles, dmem_req=0, back to IDLE.
//  6 reset asserted in 2nd REQ cycle -> next edge all outputs 0; later ready pulse ignored.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: byte-lane requests, load formatting,
// pipeline stall during the access and abort on a hung memory.
module mem_access_unit #(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [63:0] address,
  input  logic [63:0] store_data,
  input  logic        dmem_ready,
  input  logic [63:0] dmem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  output logic [7:0]  dmem_be,
  output logic [63:0] read_data_out,
  output logic        stall,
  output logic        align_fault,
  output logic        bus_error
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;

  localparam int unsigned CW = $clog2(WAIT_LIMIT + 2);
  localparam logic [CW-1:0] LIM_M1 =
    CW'((WAIT_LIMIT == 0) ? 0 : WAIT_LIMIT - 1);

  state_e        state_q, state_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [63:0]   addr_q, addr_d;
  logic [63:0]   wdata_q, wdata_d;
  logic [7:0]    be_q, be_d;
  logic [1:0]    size_q, size_d;
  logic          sext_q, sext_d;
  logic [2:0]    lane_q, lane_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0]   rdata_q, rdata_d;
  logic          berr_q, berr_d;

  logic          aligned;
  logic [7:0]    be_base;
  logic [63:0]   shifted;
  logic [63:0]   fmt;

  always_comb begin
    aligned = 1'b1;
    be_base = 8'h01;
    unique case (size)
      2'b00: begin aligned = 1'b1;            be_base = 8'h01; end
      2'b01: begin aligned = ~address[0];     be_base = 8'h03; end
      2'b10: begin aligned = ~|address[1:0];  be_base = 8'h0F; end
      default: begin aligned = ~|address[2:0]; be_base = 8'hFF; end
    endcase
  end

  // Load formatting uses the op attributes captured at request time.
  always_comb begin
    shifted = dmem_rdata >> {lane_q, 3'b000};
    fmt     = shifted;
    unique case (size_q)
      2'b00: fmt = sext_q ? {{56{shifted[7]}}, shifted[7:0]}
                          : {56'b0, shifted[7:0]};
      2'b01: fmt = sext_q ? {{48{shifted[15]}}, shifted[15:0]}
                          : {48'b0, shifted[15:0]};
      2'b10: fmt = sext_q ? {{32{shifted[31]}}, shifted[31:0]}
                          : {32'b0, shifted[31:0]};
      default: fmt = shifted;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    size_d      = size_q;
    sext_d      = sext_q;
    lane_d      = lane_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    berr_d      = 1'b0;
    stall       = 1'b0;
    align_fault = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_read | mem_write) begin
          if (aligned) begin
            stall   = 1'b1;
            req_d   = 1'b1;
            we_d    = ~mem_read;
            addr_d  = {address[63:3], 3'b000};
            wdata_d = mem_read ? 64'b0
                               : store_data << {address[2:0], 3'b000};
            be_d    = mem_read ? 8'h00 : be_base << address[2:0];
            size_d  = size;
            sext_d  = sign_ext;
            lane_d  = address[2:0];
            cnt_d   = '0;
            state_d = REQ;
          end else begin
            align_fault = 1'b1;
          end
        end
      end
      REQ: begin
        stall = 1'b1;
        if (dmem_ready) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          addr_d  = '0;
          wdata_d = '0;
          be_d    = '0;
          rdata_d = we_q ? 64'b0 : fmt;
          state_d = DONE;
        end else if ((WAIT_LIMIT != 0) && (cnt_q == LIM_M1)) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          addr_d  = '0;
          wdata_d = '0;
          be_d    = '0;
          berr_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      size_q  <= '0;
      sext_q  <= 1'b0;
      lane_q  <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
      lane_q  <= lane_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      berr_q  <= berr_d;
    end
  end

  assign dmem_req      = req_q;
  assign dmem_we       = we_q;
  assign dmem_addr     = addr_q;
  assign dmem_wdata    = wdata_q;
  assign dmem_be       = be_q;
  assign bus_error     = berr_q;
  assign read_data_out = (state_q == DONE) ? rdata_q : 64'b0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: vector table plus timeout
// and mid-request reset sequences.
module tb_mem_access_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_read, mem_write;
  logic [1:0]  size;
  logic        sign_ext;
  logic [63:0] address, store_data;
  logic        dmem_ready;
  logic [63:0] dmem_rdata;
  logic        dmem_req, dmem_we;
  logic [63:0] dmem_addr, dmem_wdata;
  logic [7:0]  dmem_be;
  logic [63:0] read_data_out;
  logic        stall, align_fault, bus_error;

  int checks = 0;
  int failures = 0;

  mem_access_unit #(.WAIT_LIMIT(4)) dut (
    .clock(clock), .reset(reset),
    .mem_read(mem_read), .mem_write(mem_write),
    .size(size), .sign_ext(sign_ext),
    .address(address), .store_data(store_data),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .read_data_out(read_data_out),
    .stall(stall), .align_fault(align_fault),
    .bus_error(bus_error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  sz;
    logic        sx;
    logic [63:0] addr;
    logic [63:0] sdata;
    logic [63:0] rdata;
    int          waits;
    logic        fault;
    logic        we;
    logic [63:0] eaddr;
    logic [63:0] ewdata;
    logic [7:0]  ebe;
    logic [63:0] erdo;
  } vec_t;

  vec_t v[13];

  function automatic vec_t mk(
    logic rd, logic wr, logic [1:0] sz, logic sx,
    logic [63:0] addr, logic [63:0] sdata, logic [63:0] rdata,
    int waits, logic fault, logic we, logic [63:0] eaddr,
    logic [63:0] ewdata, logic [7:0] ebe, logic [63:0] erdo);
    vec_t t;
    t.rd = rd; t.wr = wr; t.sz = sz; t.sx = sx;
    t.addr = addr; t.sdata = sdata; t.rdata = rdata;
    t.waits = waits; t.fault = fault; t.we = we;
    t.eaddr = eaddr; t.ewdata = ewdata; t.ebe = ebe; t.erdo = erdo;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic clear_ops();
    mem_read = 1'b0; mem_write = 1'b0; size = 2'b00;
    sign_ext = 1'b0; address = '0; store_data = '0;
  endtask

  task automatic run_vec(input int idx);
    vec_t t;
    int st;
    t = v[idx];
    st = 0;
    @(posedge clock); #1;
    mem_read = t.rd; mem_write = t.wr; size = t.sz;
    sign_ext = t.sx; address = t.addr; store_data = t.sdata;
    dmem_ready = 1'b0;
    @(negedge clock);
    st += int'(stall);
    chk($sformatf("v%0d align_fault", idx), align_fault, t.fault);
    @(posedge clock); #1;
    clear_ops();
    if (t.fault) begin
      chk($sformatf("v%0d fault stall", idx), st, 0);
      @(negedge clock);
      chk($sformatf("v%0d fault no req", idx), dmem_req, 0);
      chk($sformatf("v%0d fault pulse end", idx), align_fault, 0);
    end else begin
      for (int k = 0; k <= t.waits; k++) begin
        @(negedge clock);
        st += int'(stall);
        chk($sformatf("v%0d req c%0d", idx, k), dmem_req, 1);
        if (k == 0) begin
          chk($sformatf("v%0d we", idx), dmem_we, t.we);
          chk($sformatf("v%0d addr", idx), dmem_addr, t.eaddr);
          chk($sformatf("v%0d wdata", idx), dmem_wdata, t.ewdata);
          chk($sformatf("v%0d be", idx), dmem_be, t.ebe);
        end
        if (k == t.waits) begin
          dmem_ready = 1'b1;
          dmem_rdata = t.rdata;
        end
        @(posedge clock); #1;
        dmem_ready = 1'b0;
        dmem_rdata = 64'hDEAD_BEEF_0BAD_F00D;
      end
      @(negedge clock);
      st += int'(stall);
      chk($sformatf("v%0d read_data_out", idx), read_data_out, t.erdo);
      chk($sformatf("v%0d done req", idx), dmem_req, 0);
      chk($sformatf("v%0d stall cycles", idx), st, t.waits + 2);
      @(posedge clock); #1;
      @(negedge clock);
      chk($sformatf("v%0d idle rdo", idx), read_data_out, 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    v[0]  = mk(1,0,2'b11,0,64'h1000,0,64'h1122334455667788,0,
               0,0,64'h1000,0,8'h00,64'h1122334455667788);
    v[1]  = mk(1,0,2'b00,1,64'h1003,0,64'h0000000080000000,0,
               0,0,64'h1000,0,8'h00,64'hFFFFFFFFFFFFFF80);
    v[2]  = mk(1,0,2'b00,0,64'h1003,0,64'h0000000080000000,0,
               0,0,64'h1000,0,8'h00,64'h0000000000000080);
    v[3]  = mk(0,1,2'b01,0,64'h2006,64'hABCD,0,3,
               0,1,64'h2000,64'hABCD000000000000,8'hC0,0);
    v[4]  = mk(1,0,2'b10,0,64'h3002,0,0,0,1,0,0,0,0,0);
    v[5]  = mk(1,0,2'b10,1,64'h4004,0,64'h89ABCDEF00000000,1,
               0,0,64'h4000,0,8'h00,64'hFFFFFFFF89ABCDEF);
    v[6]  = mk(1,0,2'b01,1,64'h5002,0,64'h0000000080010000,2,
               0,0,64'h5000,0,8'h00,64'hFFFFFFFFFFFF8001);
    v[7]  = mk(1,0,2'b01,0,64'h5006,0,64'hF00D000000000000,0,
               0,0,64'h5000,0,8'h00,64'h000000000000F00D);
    v[8]  = mk(0,1,2'b11,0,64'h6000,64'h0123456789ABCDEF,0,0,
               0,1,64'h6000,64'h0123456789ABCDEF,8'hFF,0);
    v[9]  = mk(0,1,2'b00,0,64'h7005,64'h5A,0,1,
               0,1,64'h7000,64'h00005A0000000000,8'h20,0);
    v[10] = mk(0,1,2'b10,0,64'h8004,64'hDEADBEEF,0,0,
               0,1,64'h8000,64'hDEADBEEF00000000,8'hF0,0);
    v[11] = mk(0,1,2'b01,0,64'h9001,64'h1,0,0,1,0,0,0,0,0);
    v[12] = mk(1,1,2'b11,1,64'hB000,64'h1234,64'h8000000000000001,0,
               0,0,64'hB000,0,8'h00,64'h8000000000000001);

    reset = 1'b1;
    clear_ops();
    dmem_ready = 1'b0;
    dmem_rdata = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst req", dmem_req, 0);
    chk("rst we", dmem_we, 0);
    chk("rst addr", dmem_addr, 0);
    chk("rst wdata", dmem_wdata, 0);
    chk("rst be", dmem_be, 0);
    chk("rst rdo", read_data_out, 0);
    chk("rst stall", stall, 0);
    chk("rst berr", bus_error, 0);
    @(posedge clock); #1;
    reset = 1'b0;

    for (int i = 0; i < 13; i++) run_vec(i);

    // Hung memory: abort after four REQ cycles.
    @(posedge clock); #1;
    mem_read = 1'b1; size = 2'b11; address = 64'hC000;
    @(negedge clock);
    chk("to start stall", stall, 1);
    @(posedge clock); #1;
    clear_ops();
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk($sformatf("to req c%0d", k), dmem_req, 1);
      chk($sformatf("to berr c%0d", k), bus_error, 0);
      @(posedge clock); #1;
    end
    @(negedge clock);
    chk("to berr pulse", bus_error, 1);
    chk("to req drop", dmem_req, 0);
    chk("to stall", stall, 0);
    chk("to rdo", read_data_out, 0);
    @(posedge clock); #1;
    @(negedge clock);
    chk("to berr end", bus_error, 0);

    // Reset during the second REQ cycle.
    @(posedge clock); #1;
    mem_read = 1'b1; size = 2'b11; address = 64'hD000;
    @(posedge clock); #1;
    clear_ops();
    @(negedge clock);
    chk("rr req c1", dmem_req, 1);
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    chk("rr req c2", dmem_req, 1);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("rr req", dmem_req, 0);
    chk("rr addr", dmem_addr, 0);
    chk("rr stall", stall, 0);
    chk("rr berr", bus_error, 0);
    dmem_ready = 1'b1;
    dmem_rdata = 64'h7777777777777777;
    @(posedge clock); #1;
    dmem_ready = 1'b0;
    @(negedge clock);
    chk("rr ignore rdo", read_data_out, 0);
    chk("rr ignore req", dmem_req, 0);
    @(posedge clock); #1;
    @(negedge clock);
    chk("rr ignore rdo2", read_data_out, 0);
    chk("rr ignore berr", bus_error, 0);

    run_vec(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
